mc_fork_sched: RTL and testbench



---
 rtl/mc_pkg.sv | 25 ++
 rtl/mc_fork_sched_if.sv | 13 +
 rtl/mc_pick3.sv | 38 +++
 rtl/mc_fork_sched.sv | 136 +++++++++++++
 tb/tb_mc_fork_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared constants and FSM state type for the multicast fork scheduler.
// Direction one-hot encodings, dst-list field positions and scheduler states.
package mc_pkg;

  localparam logic [4:0] DIR_L = 5'b00001;
  localparam logic [4:0] DIR_S = 5'b00010;
  localparam logic [4:0] DIR_E = 5'b00100;
  localparam logic [4:0] DIR_W = 5'b01000;
  localparam logic [4:0] DIR_N = 5'b10000;

  localparam int DST_HI = 24;
  localparam int DST_LO = 9;
  localparam int E_HI   = 24;
  localparam int E_LO   = 17;
  localparam int L_BIT  = 13;
  localparam int S_HI   = 12;
  localparam int S_LO   = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/mc_fork_sched_if.sv
// Crossbar-request bus: one selected copy per cycle, accepted when port_ready[out_dir] is high.
interface mc_fork_sched_if #(
  parameter int DATASIZE = 30,
  parameter int PORTS    = 5
) ();
  logic [DATASIZE-1:0] out_data;
  logic [PORTS-1:0]    out_dir;
  logic                out_valid;
  logic [PORTS-1:0]    port_ready;

  modport master (output out_data, output out_dir, output out_valid, input port_ready);
  modport slave  (input out_data, input out_dir, input out_valid, output port_ready);
endinterface

// File: rtl/mc_pick3.sv
// 3-way one-hot pick among eligible copies; combinational, zero latency.
// MC_FORK_RR_EN: round-robin search from ptr; otherwise fixed priority copy1 > copy2 > copy3.
module mc_pick3 (
  input  logic [2:0] eligible,
  input  logic [1:0] ptr,
  output logic [2:0] grant
);

`ifdef MC_FORK_RR_EN
  logic [2:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && eligible[idx[1:0]]) begin
        grant[idx[1:0]] = 1'b1;
        found           = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant    = '0;
    grant[0] = eligible[0];
    grant[1] = eligible[1] & ~eligible[0];
    grant[2] = eligible[2] & ~(|eligible[1:0]);
  end
`endif

endmodule

// File: rtl/mc_fork_sched.sv
// Multicast fork sequencer: captures one flit, then issues its E/L/S copies one per cycle (min 2+n cycles/flit).
// Copies wait on per-port readiness with no timeout; MC_FORK_RR_EN selects round-robin over fixed priority.
module mc_fork_sched
  import mc_pkg::*;
#(
  parameter int DATASIZE = 30,
  parameter int PORTS    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                rc_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                rc_ready,
  input  logic [DATASIZE-1:0] copy_data1,
  input  logic [DATASIZE-1:0] copy_data2,
  input  logic [DATASIZE-1:0] copy_data3,
  input  logic [PORTS-1:0]    copy_dir1,
  input  logic [PORTS-1:0]    copy_dir2,
  input  logic [PORTS-1:0]    copy_dir3,
  mc_fork_sched_if.master     xb,
  output logic                busy,
  output logic                drop_pulse,
  output logic [CNT_W-1:0]    fork_cnt
);

  state_t           state_q, state_d;
  logic [2:0]       need_q, need_d;
  logic [2:0]       need_in, need_capt, eligible, grant;
  logic [1:0]       ptr;
  logic             xfer;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_in;

  // Pending bit order: [0] E copy, [1] L copy, [2] S copy.
  assign need_in   = {|in_data[S_HI:S_LO], in_data[L_BIT], |in_data[E_HI:E_LO]};
  assign need_capt = need_q & {|copy_dir3, |copy_dir2, |copy_dir1};
  assign unused_in = ^{in_data[DATASIZE-1:E_HI+1], in_data[E_LO-1:L_BIT+1], in_data[S_LO-1:0]};

  always_comb begin
    eligible = '0;
    if (state_q == ST_ISSUE) begin
      eligible[0] = need_q[0] & |(xb.port_ready & copy_dir1);
      eligible[1] = need_q[1] & |(xb.port_ready & copy_dir2);
      eligible[2] = need_q[2] & |(xb.port_ready & copy_dir3);
    end
  end

  mc_pick3 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant)
  );

  always_comb begin
    xb.out_valid = |eligible;
    xb.out_data  = '0;
    xb.out_dir   = '0;
    if (grant[0]) begin
      xb.out_data = copy_data1;
      xb.out_dir  = copy_dir1;
    end else if (grant[1]) begin
      xb.out_data = copy_data2;
      xb.out_dir  = copy_dir2;
    end else if (grant[2]) begin
      xb.out_data = copy_data3;
      xb.out_dir  = copy_dir3;
    end
  end

  assign xfer = xb.out_valid && |(xb.port_ready & xb.out_dir);

  always_comb begin
    state_d    = state_q;
    need_d     = need_q;
    rc_ready   = 1'b0;
    drop_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rc_ready = 1'b1;
        if (in_valid) begin
          need_d  = need_in;
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        need_d = need_capt;
        if (need_capt == 3'b000) begin
          drop_pulse = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          need_d = need_q & ~grant;
          if (need_d == 3'b000) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      need_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      need_q  <= need_d;
      if (xfer) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef MC_FORK_RR_EN
  logic [1:0] ptr_q;

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (xfer) begin
      ptr_q <= grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 2'd0;
`endif

  assign busy     = (state_q != ST_IDLE);
  assign fork_cnt = cnt_q;

endmodule

// File: tb/tb_mc_fork_sched.sv
// Directed bench for mc_fork_sched: issue order, stalls, drops, mid-issue reset and counter wrap (CNT_W = 4).
module tb_mc_fork_sched;
  import mc_pkg::*;

  logic        rc_clk;
  logic        rst_n;
  logic [29:0] in_data;
  logic        in_valid;
  logic        rc_ready;
  logic [29:0] copy_data1, copy_data2, copy_data3;
  logic [4:0]  copy_dir1, copy_dir2, copy_dir3;
  logic        busy;
  logic        drop_pulse;
  logic [3:0]  fork_cnt;

  mc_fork_sched_if #(.DATASIZE(30), .PORTS(5)) xb ();

  mc_fork_sched #(.DATASIZE(30), .PORTS(5), .CNT_W(4)) dut (
    .rc_clk     (rc_clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .rc_ready   (rc_ready),
    .copy_data1 (copy_data1),
    .copy_data2 (copy_data2),
    .copy_data3 (copy_data3),
    .copy_dir1  (copy_dir1),
    .copy_dir2  (copy_dir2),
    .copy_dir3  (copy_dir3),
    .xb         (xb.master),
    .busy       (busy),
    .drop_pulse (drop_pulse),
    .fork_cnt   (fork_cnt)
  );

  initial rc_clk = 1'b0;
  always #5 rc_clk = ~rc_clk;

  int         n_chk;
  int         n_fail;
  logic [3:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rc_clk);
    #1;
  endtask

  function automatic logic [29:0] mkflit(input logic [7:0] e, input logic l, input logic [3:0] s);
    logic [29:0] f;
    f        = 30'h2A000155;
    f[24:17] = e;
    f[13]    = l;
    f[12:9]  = s;
    return f;
  endfunction

  // Presents one flit in IDLE; returns one cycle later with the DUT in CAPT.
  task automatic load(input logic [29:0] f, input logic [4:0] d1, input logic [4:0] d2, input logic [4:0] d3);
    in_data    = f;
    copy_data1 = f ^ 30'h1;
    copy_data2 = f ^ 30'h2;
    copy_data3 = f ^ 30'h4;
    copy_dir1  = d1;
    copy_dir2  = d2;
    copy_dir3  = d3;
    in_valid   = 1'b1;
    #1;
    chk("cap_rdy", 32'(rc_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic run_flit(input string tag, input logic [29:0] f, input logic [4:0] d1,
                          input logic [4:0] d2, input logic [4:0] d3, input int exp_n);
    int n;
    n = 0;
    xb.port_ready = 5'b11111;
    load(f, d1, d2, d3);
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      if (xb.out_valid) n++;
      cyc();
    end
    chk({tag, "_done"}, 32'(busy), 32'd0);
    chk({tag, "_copies"}, 32'(n), 32'(exp_n));
    exp_cnt = exp_cnt + 4'(exp_n);
  endtask

  initial begin
    logic [4:0]  dirs [3];
    logic [29:0] first_dat;
    logic [29:0] f;
    int          lowcnt, nd, vcnt;

    n_chk = 0;
    n_fail = 0;
    exp_cnt = '0;
    rst_n = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    copy_data1 = '0; copy_data2 = '0; copy_data3 = '0;
    copy_dir1 = '0; copy_dir2 = '0; copy_dir3 = '0;
    xb.port_ready = 5'b11111;
    first_dat = '0;
    cyc();
    cyc();
    chk("rst_rc_ready", 32'(rc_ready), 32'd1);
    chk("rst_out_valid", 32'(xb.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(xb.out_data), 32'd0);
    chk("rst_out_dir", 32'(xb.out_dir), 32'd0);
    chk("rst_fork_cnt", 32'(fork_cnt), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Three copies, all ports ready: E, L, S in order.
    f = mkflit(8'h01, 1'b1, 4'h3);
    load(f, DIR_E, DIR_L, DIR_S);
    lowcnt = 0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (rc_ready) break;
      lowcnt++;
      if (xb.out_valid && nd < 3) begin
        if (nd == 0) first_dat = xb.out_data;
        dirs[nd] = xb.out_dir;
        nd++;
      end
      cyc();
    end
    chk("t1_occupancy", 32'(lowcnt + 1), 32'd5);
    chk("t1_ncopies", 32'(nd), 32'd3);
    chk("t1_dir0", 32'(dirs[0]), 32'(5'b00100));
    chk("t1_dir1", 32'(dirs[1]), 32'(5'b00001));
    chk("t1_dir2", 32'(dirs[2]), 32'(5'b00010));
    chk("t1_data0", 32'(first_dat), 32'(f ^ 30'h1));
    chk("t1_fork_cnt", 32'(fork_cnt), 32'd3);
    exp_cnt = 4'd3;

    // Empty dst list: drop in CAPT, idle next cycle.
    load(30'h0, 5'b0, 5'b0, 5'b0);
    chk("t2_drop", 32'(drop_pulse), 32'd1);
    chk("t2_valid", 32'(xb.out_valid), 32'd0);
    cyc();
    chk("t2_idle_rdy", 32'(rc_ready), 32'd1);
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_drop_gone", 32'(drop_pulse), 32'd0);

    // E needed by dst list but RC produced no direction for it: dropped.
    load(mkflit(8'h01, 1'b0, 4'h0), 5'b0, 5'b0, 5'b0);
    chk("t2b_drop", 32'(drop_pulse), 32'd1);
    cyc();
    chk("t2b_busy", 32'(busy), 32'd0);

    // S only, S port stalled for 4 issue cycles; other ports ready.
    xb.port_ready = 5'b11101;
    f = mkflit(8'h00, 1'b0, 4'h1);
    load(f, 5'b0, 5'b0, DIR_S);
    chk("t3_capt_valid", 32'(xb.out_valid), 32'd0);
    cyc();
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (xb.out_valid) vcnt++;
      cyc();
    end
    chk("t3_stall_valid", 32'(vcnt), 32'd0);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    xb.port_ready = 5'b11111;
    #1;
    chk("t3_valid", 32'(xb.out_valid), 32'd1);
    chk("t3_dir", 32'(xb.out_dir), 32'(DIR_S));
    chk("t3_data", 32'(xb.out_data), 32'(f ^ 30'h4));
    cyc();
    chk("t3_busy_done", 32'(busy), 32'd0);
    exp_cnt = exp_cnt + 4'd1;

    // E+S flit with E stalled first: S then E (leaves rr pointer at 1).
    f = mkflit(8'h10, 1'b0, 4'h8);
    xb.port_ready = 5'b11011;
    load(f, DIR_E, 5'b0, DIR_S);
    cyc();
    chk("t4a_first", 32'(xb.out_dir), 32'(DIR_S));
    cyc();
    xb.port_ready = 5'b11111;
    #1;
    chk("t4a_second", 32'(xb.out_dir), 32'(DIR_E));
    cyc();
    // Second E+S flit, all ports ready.
    load(f, DIR_E, 5'b0, DIR_S);
    cyc();
`ifdef MC_FORK_RR_EN
    chk("t4b_first", 32'(xb.out_dir), 32'(DIR_S));
    cyc();
    chk("t4b_second", 32'(xb.out_dir), 32'(DIR_E));
`else
    chk("t4b_first", 32'(xb.out_dir), 32'(DIR_E));
    cyc();
    chk("t4b_second", 32'(xb.out_dir), 32'(DIR_S));
`endif
    cyc();
    chk("t4_busy", 32'(busy), 32'd0);
    exp_cnt = exp_cnt + 4'd4;
    chk("t4_fork_cnt", 32'(fork_cnt), 32'(exp_cnt));

    // Reset during ISSUE with two copies still pending.
    f = mkflit(8'h01, 1'b1, 4'h3);
    load(f, DIR_E, DIR_L, DIR_S);
    cyc();
    chk("t5_first", 32'(xb.out_dir), 32'(DIR_E));
    cyc();
    chk("t5_pending_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rc_ready", 32'(rc_ready), 32'd1);
    chk("t5_valid", 32'(xb.out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_data", 32'(xb.out_data), 32'd0);
    chk("t5_dir", 32'(xb.out_dir), 32'd0);
    chk("t5_cnt", 32'(fork_cnt), 32'd0);
    chk("t5_drop", 32'(drop_pulse), 32'd0);
    cyc();
    rst_n = 1'b1;
    exp_cnt = '0;
    cyc();
    run_flit("t5_after", mkflit(8'h00, 1'b1, 4'h0), 5'b0, DIR_L, 5'b0, 1);
    chk("t5_after_cnt", 32'(fork_cnt), 32'(exp_cnt));

    // Counter wrap at 16 copies.
    for (int k = 0; k < 4; k++)
      run_flit("t6_full", mkflit(8'h80, 1'b1, 4'h2), DIR_E, DIR_L, DIR_S, 3);
    chk("t6_cnt13", 32'(fork_cnt), 32'd13);
    run_flit("t6_es", mkflit(8'h02, 1'b0, 4'h4), DIR_E, 5'b0, DIR_S, 2);
    chk("t6_cnt15", 32'(fork_cnt), 32'd15);
    run_flit("t6_l", mkflit(8'h00, 1'b1, 4'h0), 5'b0, DIR_L, 5'b0, 1);
    chk("t6_wrap", 32'(fork_cnt), 32'd0);
    chk("t6_model", 32'(fork_cnt), 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
